// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decoder for the 7-segment display
// drivers. All segment patterns are active-low in {CA,CB,CC,CD,CE,CF,CG}
// order. A 0 bit means the segment is lit.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [7:0] ANODES_OFF = 8'hFF;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_tick_gen.sv
// tick_gen: free-running prescaler. It counts 0..DIV-1 and asserts tick_o for
// the single cycle in which the count is DIV-1. The count then wraps to 0.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; clears the count
//   tick_o - one-cycle strobe, once every DIV cycles
module tick_gen #(
   parameter int DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick_o
);

   localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a common-anode display with
// 1..8 digits. It supports frame-synchronous input capture, per-digit enable,
// decimal points, leading-zero blanking and per-digit blink.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   data_in     - packed hex nibbles; nibble i drives digit i (0 = rightmost)
//   dp_in       - decimal point request per digit
//   digit_en    - per-digit enable
//   blink_mask  - digits that blink
//   blank_lz    - enable leading-zero blanking
//   segments    - {CA..CG}, active-low
//   dp          - decimal point segment, active-low
//   anodes      - {AN7..AN0}, one-cold, active-low
//   frame_done  - one-cycle pulse as the outputs return to digit 0
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS     = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] data_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic                  blank_lz,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic [7:0]            anodes,
   output logic                  frame_done
);

   localparam int               IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);
   localparam int               FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(BLINK_FRAMES - 1);

   logic tick;

   tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .tick_o (tick)
   );

   // Scan state
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic             blink_q, blink_d;
   logic             first_q;   // set during reset: the first live cycle takes inputs directly
   logic             adv_q;     // idx advanced on the previous edge

   // Shadow copies of the inputs, refreshed only at frame boundaries
   logic [4*N_DIGITS-1:0] data_sh_q;
   logic [N_DIGITS-1:0]   dp_sh_q, en_sh_q, blink_sh_q;
   logic                  lz_sh_q;

   // Output registers
   logic [6:0] seg_q, seg_d;
   logic [7:0] an_q, an_d;
   logic       dp_q, dp_d;
   logic       fd_q, fd_d;

   logic frame_wrap;
   logic capture;

   assign frame_wrap = tick && (idx_q == IDX_MAX);
   assign capture    = first_q || frame_wrap;

   // On the first cycle after reset the shadows are still loading. The
   // outputs therefore read the same values the shadows are about to take.
   logic [4*N_DIGITS-1:0] src_data;
   logic [N_DIGITS-1:0]   src_dp, src_en, src_blink;
   logic                  src_lz;

   assign src_data  = first_q ? data_in    : data_sh_q;
   assign src_dp    = first_q ? dp_in      : dp_sh_q;
   assign src_en    = first_q ? digit_en   : en_sh_q;
   assign src_blink = first_q ? blink_mask : blink_sh_q;
   assign src_lz    = first_q ? blank_lz   : lz_sh_q;

   // upper_zero[i]: nibbles i..N_DIGITS-1 are all zero
   logic [3:0]          nib [N_DIGITS];
   logic [N_DIGITS-1:0] upper_zero;

   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         assign nib[gi]        = src_data[4*gi +: 4];
         assign upper_zero[gi] = (src_data[4*N_DIGITS-1:4*gi] == '0);
      end
   endgenerate

   logic blanked;

   always_comb begin
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      if (frame_wrap) begin
         idx_d = '0;
         if (frame_cnt_q == FR_MAX) begin
            frame_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FR_W'(1);
         end
      end else if (tick) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_comb begin
      blanked = !src_en[idx_q]
             || (src_blink[idx_q] && blink_q)
             || (src_lz && (idx_q != '0) && upper_zero[idx_q]);
      an_d    = ANODES_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      if (!blanked) begin
         an_d  = ANODES_OFF & ~(8'd1 << idx_q);
         seg_d = hex_to_seg(nib[idx_q]);
         dp_d  = ~src_dp[idx_q];
      end
      // The outputs settle on digit 0 one edge after idx wraps.
      fd_d = adv_q && (idx_q == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         frame_cnt_q <= '0;
         blink_q     <= 1'b0;
         first_q     <= 1'b1;
         adv_q       <= 1'b0;
         data_sh_q   <= '0;
         dp_sh_q     <= '0;
         en_sh_q     <= '0;
         blink_sh_q  <= '0;
         lz_sh_q     <= 1'b0;
         seg_q       <= SEG_BLANK;
         an_q        <= ANODES_OFF;
         dp_q        <= 1'b1;
         fd_q        <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
         first_q     <= 1'b0;
         adv_q       <= tick;
         if (capture) begin
            data_sh_q  <= data_in;
            dp_sh_q    <= dp_in;
            en_sh_q    <= digit_en;
            blink_sh_q <= blink_mask;
            lz_sh_q    <= blank_lz;
         end
         seg_q <= seg_d;
         an_q  <= an_d;
         dp_q  <= dp_d;
         fd_q  <= fd_d;
      end
   end

   assign segments   = seg_q;
   assign anodes     = an_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner. An 8-digit and a 4-digit instance
// share the clock and reset. Both use REFRESH_DIV=4 and BLINK_FRAMES=2.
// Cycle index k counts edges after reset release. Edge 0 is the first edge
// at which reset is low. Outputs are sampled 1 time unit after each edge.
module tb_seven_seg_scanner;

   localparam int DIV = 4;
   localparam int BF  = 2;

   logic clk = 1'b0;
   logic reset;

   logic [31:0] data8;
   logic [7:0]  dp8, en8, blink8;
   logic        lz8;
   logic [6:0]  seg8;
   logic        dpo8;
   logic [7:0]  an8;
   logic        fd8;

   logic [15:0] data4;
   logic [3:0]  dp4, en4, blink4;
   logic        lz4;
   logic [6:0]  seg4;
   logic        dpo4;
   logic [7:0]  an4;
   logic        fd4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.N_DIGITS(8), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data8),
      .dp_in      (dp8),
      .digit_en   (en8),
      .blink_mask (blink8),
      .blank_lz   (lz8),
      .segments   (seg8),
      .dp         (dpo8),
      .anodes     (an8),
      .frame_done (fd8)
   );

   seven_seg_scanner #(.N_DIGITS(4), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data4),
      .dp_in      (dp4),
      .digit_en   (en4),
      .blink_mask (blink4),
      .blank_lz   (lz4),
      .segments   (seg4),
      .dp         (dpo4),
      .anodes     (an4),
      .frame_done (fd4)
   );

   // Hand-decoded expectations for data 32'h1234ABCD, listed from digit 0 up.
   logic [6:0] seg_1234abcd [8] = '{7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000,
                                    7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
   logic [7:0] an_one_cold  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   // 4-digit instance, data 16'h00F0 with leading-zero blanking on
   logic [7:0] an4_exp  [4] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF};
   logic [6:0] seg4_exp [4] = '{7'b0000001, 7'b0111000, 7'h7F, 7'h7F};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset  = 1'b1;
      data8  = 32'h1234ABCD; dp8 = 8'h00; en8 = 8'hFF; blink8 = 8'h00; lz8 = 1'b0;
      data4  = 16'h00F0;     dp4 = 4'h0;  en4 = 4'hF;  blink4 = 4'h0;  lz4 = 1'b1;

      // ---- reset state ----
      repeat (3) step();
      check("rst_an8",  an8,  8'hFF);
      check("rst_seg8", seg8, 7'h7F);
      check("rst_dp8",  dpo8, 1'b1);
      check("rst_fd8",  fd8,  1'b0);
      check("rst_an4",  an4,  8'hFF);
      check("rst_fd4",  fd4,  1'b0);
      $display("txn reset_state checks=%0d errors=%0d", checks, errors);

      // ---- basic scan (8 digits) and leading-zero blanking (4 digits) ----
      reset = 1'b0;
      for (int k = 0; k <= 32; k++) begin
         int s8, s4;
         step();
         s8 = (k / 4) % 8;
         s4 = (k / 4) % 4;
         check("scan_an8",  an8,  an_one_cold[s8]);
         check("scan_seg8", seg8, seg_1234abcd[s8]);
         check("scan_dp8",  dpo8, 1'b1);
         check("scan_fd8",  fd8,  (k == 32) ? 1'b1 : 1'b0);
         check("lz_an4",    an4,  an4_exp[s4]);
         check("lz_seg4",   seg4, seg4_exp[s4]);
         check("lz_fd4",    fd4,  (k == 16 || k == 32) ? 1'b1 : 1'b0);
      end
      step();
      check("scan_fd8_low", fd8, 1'b0);
      $display("txn scan_and_lz checks=%0d errors=%0d", checks, errors);

      // ---- frame coherence: data changes while digit 3 is lit ----
      reset = 1'b1;
      data8 = 32'h0;
      repeat (2) step();
      reset = 1'b0;
      for (int k = 0; k < 64; k++) begin
         step();
         check("coh_an8",  an8,  an_one_cold[(k / 4) % 8]);
         check("coh_seg8", seg8, (k < 32) ? 7'b0000001 : 7'b0111000);
         if (k == 13) data8 = 32'hFFFFFFFF;
      end
      $display("txn frame_coherence checks=%0d errors=%0d", checks, errors);

      // ---- blink on digit 0, digit 2 disabled ----
      reset  = 1'b1;
      data8  = 32'h1234ABCD;
      dp8    = 8'h01;
      blink8 = 8'h01;
      en8    = 8'hFB;
      repeat (2) step();
      reset = 1'b0;
      for (int k = 0; k < 160; k++) begin
         int  f, s;
         logic on;
         step();
         f  = k / 32;
         s  = (k % 32) / 4;
         on = ((f % 4) < 2);
         if (s == 0) begin
            check("blink_an0",  an8,  on ? 8'hFE : 8'hFF);
            check("blink_seg0", seg8, on ? 7'b1000010 : 7'h7F);
            check("blink_dp0",  dpo8, on ? 1'b0 : 1'b1);
         end else if (s == 1) begin
            check("blink_an1",  an8,  8'hFD);
            check("blink_seg1", seg8, 7'b0110001);
            check("blink_dp1",  dpo8, 1'b1);
         end else if (s == 2) begin
            check("dis_an2",  an8,  8'hFF);
            check("dis_seg2", seg8, 7'h7F);
         end
      end
      $display("txn blink checks=%0d errors=%0d", checks, errors);

      // ---- reset asserted mid-frame while digit 5 is selected ----
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      for (int k = 0; k <= 20; k++) step();
      check("mid_an5", an8, 8'hDF);
      reset = 1'b1;
      step();
      check("mid_rst_an",  an8,  8'hFF);
      check("mid_rst_seg", seg8, 7'h7F);
      check("mid_rst_dp",  dpo8, 1'b1);
      reset = 1'b0;
      step();
      check("rel_an",  an8,  8'hFE);
      check("rel_seg", seg8, 7'b1000010);
      check("rel_dp",  dpo8, 1'b0);
      repeat (3) step();
      check("rel_an_hold", an8, 8'hFE);
      step();
      check("rel_an_next", an8, 8'hFD);
      $display("txn reset_mid_frame checks=%0d errors=%0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for the Nexys A7 eight-digit common-anode 7-segment display. It generalises the fixed four-digit scan to 1–8 digits, adds an internal refresh prescaler, frame-synchronous data capture, per-digit enable, decimal points, leading-zero blanking and per-digit blink. It sits between any datapath that exposes a packed hex word (ALU result, counters) and the board pins.

## Interface
- N_DIGITS, 8: number of scanned digits, 1..8; anodes above N_DIGITS-1 are held off.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be ≥ 1.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- data_in  in  4*N_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost, AN0).
- dp_in  in  N_DIGITS  decimal point request per digit, active-high.
- digit_en  in  N_DIGITS  per-digit enable; 0 keeps that anode off.
- blink_mask  in  N_DIGITS  digits that blink.
- blank_lz  in  1  enable leading-zero blanking.
- segments  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low.
- dp  out  1  DP segment, active-low.
- anodes  out  8  {AN7..AN0}, one-cold, active-low.
- frame_done  out  1  one-cycle pulse when digit N_DIGITS-1's slot ends.

## Operation
- Prescaler counts 0..REFRESH_DIV-1; `tick` is asserted for one cycle at REFRESH_DIV-1, then the prescaler wraps to 0.
- Scan index `idx` (width clog2(N_DIGITS), minimum 1) advances on `tick` and wraps N_DIGITS-1 → 0. For N_DIGITS=1, idx stays 0.
- Shadow registers capture data_in, dp_in, digit_en, blink_mask and blank_lz on reset release and on every `tick` where idx wraps to 0. Inputs are sampled only at frame boundaries, so a displayed frame never tears.
- Blink: the frame counter counts frame_done pulses 0..BLINK_FRAMES-1 and toggles `blink_phase` on wrap. blink_phase resets to 0, which means visible.
- Digit i is blanked when any of the following holds:
  - the shadow digit_en[i] is 0, or
  - shadow blink_mask[i] is 1 and blink_phase is 1, or
  - shadow blank_lz is 1, i ≠ 0, and shadow nibbles i..N_DIGITS-1 are all 0.
- A blanked digit drives anodes all 1 and segments 7'h7F.
- Encoding, 0 = lit: 0→0000001, 1→1001111, 2→0010010, 3→0000110, 4→1001100, 5→0100100, 6→0100000, 7→0001111, 8→0000000, 9→0000100, A→0001000, b→1100000, C→0110001, d→1000010, E→0110000, F→0111000.
- dp = ~shadow dp_in[idx] when the digit is not blanked; otherwise dp = 1.

## Timing
- Reset values:
  - prescaler 0, idx 0, frame counter 0, blink_phase 0.
  - shadows 0.
  - anodes 8'hFF, segments 7'h7F, dp 1, frame_done 0.
- All outputs are registered. anodes, segments and dp update exactly 1 cycle after the `tick` that changes idx, and hold for REFRESH_DIV cycles.
- The first lit digit after reset appears 1 cycle after reset deasserts, showing digit 0 from the captured shadow.
- frame_done is registered. It is high in the same cycle the outputs switch back to digit 0.
- A data_in change lands on the display at the next frame boundary. Worst-case latency is N_DIGITS*REFRESH_DIV + 1 cycles.
- Reset mid-frame takes priority over everything, including a coincident `tick`, and restarts the scan at digit 0.
- Anode and segment changes occur in the same cycle. No ghosting gap is inserted.

## Structure
- Package `seven_seg_pkg` holds:
  - SEG_BLANK = 7'h7F and ANODES_OFF = 8'hFF;
  - the `hex_to_seg` function (the 16-entry table above).
- Sub-module `tick_gen #(DIV)`: a free-running prescaler with a single-cycle `tick` output. It is reusable by the other board-level blocks.
- Everything else (scan index, shadows, blink logic, blank logic, output registers) lives in seven_seg_scanner.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_FRAMES=2.
- Reset scan, N_DIGITS=8, data_in=32'h1234ABCD, all enabled:
  - anodes cycle FE, FD, FB, … 7F, with each value lasting 4 cycles;
  - segments under AN0 = 1000010 (d), under AN7 = 1001111 (1);
  - frame_done pulses every 32 cycles.
- N_DIGITS=4, data_in=16'h00F0, blank_lz=1:
  - AN3 and AN2 stay off during their slots;
  - AN1 shows F (0111000) and AN0 shows 0 (0000001);
  - anodes[7:4] stay 1 throughout.
- Frame coherence: change data_in from 32'h0 to 32'hFFFFFFFF while digit 3 is lit:
  - digits 3–7 still show 0 for the rest of that frame;
  - all digits show F from the next frame on.
- Blink: blink_mask=8'h01, dp_in=8'h01:
  - digit 0 is lit with dp=0 for 2 frames, then blanked with dp=1 for 2 frames, repeating;
  - the other digits are unaffected.
- Reset asserted mid-frame at idx=5:
  - next cycle anodes=FF and segments=7F;
  - 1 cycle after release, anodes=FE.
